// File: rtl/fdc_pkg.sv
// Shared types and default timing for the floppy seek controller.
// Command encodings, FSM state enum and a small sizing helper.
package fdc_pkg;

  localparam int TRACK_W = 7;
  localparam int DRIVE_W = 4;

  localparam logic OP_SEEK  = 1'b0;
  localparam logic OP_RECAL = 1'b1;

  localparam int DEF_DRIVE_NUM      = 1;
  localparam int DEF_MAX_TRACKS     = 80;
  localparam int DEF_STEP_PULSE_CYC = 400;
  localparam int DEF_STEP_RATE_CYC  = 300000;
  localparam int DEF_DIR_SETUP_CYC  = 100;
  localparam int DEF_SETTLE_CYC     = 750000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIR_SETUP,
    ST_STEP_LO,
    ST_STEP_WAIT,
    ST_SETTLE,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fdc_sync2.sv
// Two-flop synchroniser for an asynchronous bus input.
// Both flops reset to RST_VAL so an idle (high) bus line reads inactive.
module fdc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fdc_seek_ctrl.sv
// Floppy drive seek/recalibrate controller: generates step/direction on
// the drive bus, tracks the head position and reports completion.
module fdc_seek_ctrl
  import fdc_pkg::*;
#(
  parameter int DRIVE_NUM      = DEF_DRIVE_NUM,
  parameter int MAX_TRACKS     = DEF_MAX_TRACKS,
  parameter int STEP_PULSE_CYC = DEF_STEP_PULSE_CYC,
  parameter int STEP_RATE_CYC  = DEF_STEP_RATE_CYC,
  parameter int DIR_SETUP_CYC  = DEF_DIR_SETUP_CYC,
  parameter int SETTLE_CYC     = DEF_SETTLE_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [TRACK_W-1:0] cmd_track,
  input  logic               motor_req,
  output logic [DRIVE_W-1:0] drive_sel_n,
  output logic               motor_on_n,
  output logic               dir_sel_n,
  output logic               step_n,
  input  logic               index_n,
  input  logic               track_0_n,
  output logic               index_pulse,
  output logic [TRACK_W-1:0] cur_track,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int TMR_MAX = max_int(max_int(STEP_RATE_CYC, SETTLE_CYC), DIR_SETUP_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]   TMR_DIR    = TMR_W'(DIR_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0]   TMR_LO     = TMR_W'(STEP_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0]   TMR_WAIT   = TMR_W'(STEP_RATE_CYC - STEP_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0]   TMR_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TRACK_W-1:0] TRK_LIMIT  = TRACK_W'(MAX_TRACKS);
  localparam logic [TRACK_W-1:0] TRK_LAST   = TRACK_W'(MAX_TRACKS - 1);
  localparam logic [DRIVE_W-1:0] SEL_MASK   = DRIVE_W'(1) << DRIVE_NUM;

  state_t               state, state_nxt;
  logic [TMR_W-1:0]     tmr;
  logic [TRACK_W-1:0]   steps_left;
  logic                 op_recal;
  logic                 idx_sync, t0_sync, idx_prev;
  logic                 step_d;
  logic [DRIVE_W-1:0]   drive_d;

  fdc_sync2 u_sync_index (.clk(clk), .rst(rst), .d(index_n),   .q(idx_sync));
  fdc_sync2 u_sync_t0    (.clk(clk), .rst(rst), .d(track_0_n), .q(t0_sync));

  logic               accept, tmr_zero, step_exit, wait_end, t0_hit, stop_stepping;
  logic               seek_bad, seek_same, seek_up;
  logic [TRACK_W-1:0] seek_dist;

  assign accept        = cmd_valid && (state == ST_IDLE);
  assign tmr_zero      = (tmr == '0);
  assign step_exit     = (state == ST_STEP_LO) && tmr_zero;
  assign wait_end      = (state == ST_STEP_WAIT) && tmr_zero;
  assign t0_hit        = ~t0_sync;
  assign stop_stepping = (op_recal && t0_hit) || (steps_left == '0);
  assign seek_bad      = (cmd_track >= TRK_LIMIT);
  assign seek_same     = (cmd_track == cur_track);
  assign seek_up       = (cmd_track > cur_track);
  assign seek_dist     = seek_up ? (cmd_track - cur_track) : (cur_track - cmd_track);

  function automatic logic [TMR_W-1:0] tmr_load(input state_t s);
    case (s)
      ST_DIR_SETUP: return TMR_DIR;
      ST_STEP_LO:   return TMR_LO;
      ST_STEP_WAIT: return TMR_WAIT;
      ST_SETTLE:    return TMR_SETTLE;
      default:      return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_RECAL) state_nxt = t0_hit ? ST_DONE : ST_DIR_SETUP;
          else if (seek_bad || seek_same) state_nxt = ST_DONE;
          else state_nxt = ST_DIR_SETUP;
        end
      end
      ST_DIR_SETUP: if (tmr_zero) state_nxt = ST_STEP_LO;
      ST_STEP_LO:   if (tmr_zero) state_nxt = ST_STEP_WAIT;
      ST_STEP_WAIT: if (tmr_zero) state_nxt = stop_stepping ? ST_SETTLE : ST_STEP_LO;
      ST_SETTLE:    if (tmr_zero) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they change glitch-free with it.
  always_comb begin
    step_d  = (state_nxt != ST_STEP_LO);
    drive_d = ((state_nxt != ST_IDLE) || motor_req) ? ~SEL_MASK : '1;
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_n      <= 1'b1;
      drive_sel_n <= '1;
      motor_on_n  <= 1'b1;
      idx_prev    <= 1'b1;
      index_pulse <= 1'b0;
    end else begin
      step_n      <= step_d;
      drive_sel_n <= drive_d;
      motor_on_n  <= ~motor_req;
      idx_prev    <= idx_sync;
      index_pulse <= idx_prev & ~idx_sync;
    end
  end

  // Timer is reloaded on every state change and counts down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr        <= '0;
      steps_left <= '0;
      op_recal   <= 1'b0;
      dir_sel_n  <= 1'b1;
      cur_track  <= '0;
      error      <= 1'b0;
    end else begin
      if (state_nxt != state) tmr <= tmr_load(state_nxt);
      else if (!tmr_zero)     tmr <= tmr - 1'b1;

      if (accept) begin
        op_recal <= (cmd_op == OP_RECAL);
        error    <= (cmd_op == OP_SEEK) && seek_bad;
        if (cmd_op == OP_RECAL) begin
          dir_sel_n  <= 1'b1;
          steps_left <= TRK_LIMIT;
          if (t0_hit) cur_track <= '0;
        end else if (!seek_bad && !seek_same) begin
          dir_sel_n  <= ~seek_up;
          steps_left <= seek_dist;
        end
      end

      if (step_exit) begin
        steps_left <= steps_left - 1'b1;
        if (!dir_sel_n) begin
          if (cur_track != TRK_LAST) cur_track <= cur_track + 1'b1;
        end else if (cur_track != '0) begin
          cur_track <= cur_track - 1'b1;
        end
      end

      // RECAL always ends at track 0: found it, or ran out of steps and forces it.
      if (wait_end && op_recal && stop_stepping) begin
        cur_track <= '0;
        if (!t0_hit) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fdc_seek_ctrl.sv
// Scoreboard bench for fdc_seek_ctrl with short timing parameters.
// Stimulus queues expected completions; a monitor checks each done pulse.
module tb_fdc_seek_ctrl;

  localparam int PULSE  = 4;
  localparam int RATE   = 20;
  localparam int DSETUP = 2;
  localparam int SETTLE = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [6:0] cmd_track = '0;
  logic       motor_req = 1'b1;
  logic [3:0] drive_sel_n;
  logic       motor_on_n;
  logic       dir_sel_n;
  logic       step_n;
  logic       index_n = 1'b1;
  logic       track_0_n;
  logic       index_pulse;
  logic [6:0] cur_track;
  logic       busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string name;
    int    track;
    logic  err;
    int    pulses;
  } exp_t;
  exp_t sb[$];

  logic exp_dir = 1'b1;
  int   head = 0;
  int   head_ofs = 0;
  logic t0_stuck = 1'b0;

  always #5 clk = ~clk;

  fdc_seek_ctrl #(
    .DRIVE_NUM(1), .MAX_TRACKS(80), .STEP_PULSE_CYC(PULSE),
    .STEP_RATE_CYC(RATE), .DIR_SETUP_CYC(DSETUP), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_track(cmd_track), .motor_req(motor_req),
    .drive_sel_n(drive_sel_n), .motor_on_n(motor_on_n), .dir_sel_n(dir_sel_n),
    .step_n(step_n), .index_n(index_n), .track_0_n(track_0_n),
    .index_pulse(index_pulse), .cur_track(cur_track), .busy(busy),
    .done(done), .error(error)
  );

  // Physical head model: moves on each step_n fall, stops at track 0.
  always @(negedge step_n) begin
    if (rst) begin
      if (!dir_sel_n) head = head + 1;
      else if (head + head_ofs > 0) head = head - 1;
    end
  end
  assign track_0_n = t0_stuck | ((head + head_ofs) != 0);

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: step pulse shape plus scoreboard compare on every done pulse.
  int   total_pulses = 0, base_pulses = 0, low_len = 0, since_fall = 0;
  logic first_fall = 1'b1;
  logic prev_step = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      prev_step   = 1'b1;
      low_len     = 0;
      since_fall  = 0;
      first_fall  = 1'b1;
      base_pulses = total_pulses;
    end else begin
      since_fall++;
      if (prev_step && !step_n) begin
        total_pulses++;
        check("step_dir", dir_sel_n, exp_dir);
        if (!first_fall) check("step_period", since_fall, RATE);
        since_fall = 0;
        first_fall = 1'b0;
      end
      if (!step_n) low_len++;
      else if (!prev_step) begin
        check("step_width", low_len, PULSE);
        low_len = 0;
      end
      prev_step = step_n;
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_track"}, cur_track, e.track);
          check({e.name, "_error"}, error, e.err);
          check({e.name, "_pulses"}, total_pulses - base_pulses, e.pulses);
        end
        base_pulses = total_pulses;
        first_fall  = 1'b1;
      end
    end
  end

  task automatic expect_done(input string nm, input int trk, input logic err, input int pulses);
    exp_t e;
    e.name = nm; e.track = trk; e.err = err; e.pulses = pulses;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic op, input logic [6:0] trk, input logic edir);
    int c = 0;
    while (!cmd_ready && c < 100) begin @(negedge clk); c++; end
    check("ready_wait", cmd_ready, 1);
    exp_dir   = edir;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_track = trk;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_low_busy", cmd_ready, 0);
    check("drive_sel_busy", drive_sel_n, 4'hD);
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while ((sb.size() != 0 || !cmd_ready) && c < 3000) begin @(negedge clk); c++; end
    check({nm, "_timeout"}, (c < 3000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_step_n", step_n, 1);
    check("rst_dir_sel_n", dir_sel_n, 1);
    check("rst_motor_on_n", motor_on_n, 1);
    check("rst_drive_sel_n", drive_sel_n, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_index_pulse", index_pulse, 0);
    check("rst_cur_track", cur_track, 0);
    rst = 1'b1;

    repeat (2) @(negedge clk);
    check("motor_on", motor_on_n, 0);
    check("drive_sel_motor", drive_sel_n, 4'hD);
    motor_req = 1'b0;
    repeat (2) @(negedge clk);
    check("motor_off", motor_on_n, 1);
    check("drive_sel_idle", drive_sel_n, 4'hF);

    expect_done("seek5", 5, 1'b0, 5);
    issue(1'b0, 7'd5, 1'b0);
    wait_idle("seek5");

    expect_done("seek2", 2, 1'b0, 3);
    issue(1'b0, 7'd2, 1'b1);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_track = 7'd70;
    repeat (10) @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("seek2");

    expect_done("seek80", 2, 1'b1, 0);
    issue(1'b0, 7'd80, 1'b1);
    wait_idle("seek80");

    expect_done("seek_same", 2, 1'b0, 0);
    issue(1'b0, 7'd2, 1'b1);
    wait_idle("seek_same");

    head_ofs = 5;
    repeat (4) @(negedge clk);
    expect_done("recal7", 0, 1'b0, 7);
    issue(1'b1, 7'd0, 1'b1);
    wait_idle("recal7");

    t0_stuck = 1'b1;
    repeat (4) @(negedge clk);
    expect_done("recal_stuck", 0, 1'b1, 80);
    issue(1'b1, 7'd0, 1'b1);
    wait_idle("recal_stuck");

    t0_stuck = 1'b0;
    repeat (4) @(negedge clk);
    expect_done("recal_at0", 0, 1'b0, 0);
    issue(1'b1, 7'd0, 1'b1);
    wait_idle("recal_at0");

    expect_done("seek79", 79, 1'b0, 79);
    issue(1'b0, 7'd79, 1'b0);
    wait_idle("seek79");

    begin
      int   falls = 0;
      int   c = 0;
      logic prev = 1'b1;
      issue(1'b0, 7'd60, 1'b1);
      while (falls < 3 && c < 200) begin
        if (prev && !step_n) falls++;
        prev = step_n;
        if (falls < 3) begin @(negedge clk); c++; end
      end
      check("rst_mid_step_reached", falls, 3);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_step_n", step_n, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_dir_sel_n", dir_sel_n, 1);
      check("mid_rst_drive_sel_n", drive_sel_n, 4'hF);
      check("mid_rst_motor_on_n", motor_on_n, 1);
      check("mid_rst_cur_track", cur_track, 0);
      check("mid_rst_index_pulse", index_pulse, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
    end

    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      index_n = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk);
        #1;
        check("index_pulse", index_pulse, (k == 3));
      end
      @(negedge clk);
      index_n = 1'b1;
      repeat (5) @(negedge clk);
      check("index_rise_quiet", index_pulse, 0);
    end

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fdc_seek_ctrl.md
FDC_SEEK_CTRL -- requirements
Module: fdc_seek_ctrl

Interface
REQ-001 Parameter DRIVE_NUM, default 1: index of the drive_sel_n bit asserted low while a command runs.
REQ-002 Parameter MAX_TRACKS, default 80: highest legal track + 1; also the recalibrate step limit.
REQ-003 Parameter STEP_PULSE_CYC, default 400: step_n low width, in clk cycles.
REQ-004 Parameter STEP_RATE_CYC, default 300000: step_n period, falling edge to falling edge, in clk cycles.
REQ-005 Parameter DIR_SETUP_CYC, default 100: dir_sel_n stable time before the first step_n fall.
REQ-006 Parameter SETTLE_CYC, default 750000: head settle time after the last step.
REQ-007 clk  in  1  single system clock; all logic on the rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 cmd_valid  in  1  command request.
REQ-010 cmd_ready  out  1  block accepts a command; high only in IDLE.
REQ-011 cmd_op  in  1  0 = SEEK, 1 = RECAL.
REQ-012 cmd_track  in  7  SEEK target track.
REQ-013 motor_req  in  1  host motor request.
REQ-014 drive_sel_n  out  4  bus drive select, active-low.
REQ-015 motor_on_n  out  1  bus motor on, active-low; equals ~motor_req, registered.
REQ-016 dir_sel_n  out  1  bus direction; 0 = inward (track+1), 1 = outward.
REQ-017 step_n  out  1  bus step, active-low pulse.
REQ-018 index_n  in  1  bus index, asynchronous, active-low.
REQ-019 track_0_n  in  1  bus track 00, asynchronous, active-low.
REQ-020 index_pulse  out  1  one-cycle pulse on each synchronised falling edge of index_n.
REQ-021 cur_track  out  7  current head position.
REQ-022 busy  out  1  high in any state other than IDLE.
REQ-023 done  out  1  one-cycle pulse when a command completes.
REQ-024 error  out  1  sticky error flag; cleared when the next command is accepted.

Function
REQ-025 index_n and track_0_n SHALL pass through two-flop synchronisers; all decisions use the synchronised values.
REQ-026 States SHALL be IDLE, DIR_SETUP, STEP_LO, STEP_WAIT, SETTLE, DONE.
REQ-027 A command SHALL be accepted when cmd_valid and cmd_ready are both high; cmd_op and cmd_track are latched in that cycle.
REQ-028 SEEK with cmd_track >= MAX_TRACKS SHALL set error and go to DONE without stepping.
REQ-029 SEEK with cmd_track == cur_track SHALL go directly to DONE without stepping.
REQ-030 Otherwise the SEEK step count SHALL be |cmd_track - cur_track|; dir_sel_n = 0 if the target is higher, else 1.
REQ-031 RECAL SHALL set dir_sel_n = 1; if track 00 is already active, it SHALL set cur_track = 0 and go to DONE.
REQ-032 DIR_SETUP SHALL hold for DIR_SETUP_CYC cycles, then go to STEP_LO.
REQ-033 STEP_LO SHALL drive step_n low for STEP_PULSE_CYC cycles; cur_track SHALL change by ±1 on exit.
REQ-034 STEP_WAIT SHALL keep step_n high for STEP_RATE_CYC - STEP_PULSE_CYC cycles, then go to STEP_LO again or to SETTLE.
REQ-035 RECAL SHALL stop stepping at the end of STEP_WAIT once track 00 is active, and set cur_track = 0.
REQ-036 RECAL SHALL set error after MAX_TRACKS steps without track 00; cur_track is then 0 (forced).
REQ-037 SETTLE SHALL last SETTLE_CYC cycles; DONE SHALL last one cycle, pulse done, and return to IDLE.
REQ-038 drive_sel_n[DRIVE_NUM] SHALL be 0 whenever busy or motor_req is high; all other drive_sel_n bits SHALL stay 1.
REQ-039 cmd_valid while busy SHALL be ignored; no queueing.
REQ-040 Counters SHALL be sized for STEP_RATE_CYC and SETTLE_CYC; cur_track SHALL never wrap below 0 or reach MAX_TRACKS or above.

Reset
REQ-041 While rst = 0: state = IDLE, cur_track = 0, step_n = 1, dir_sel_n = 1, motor_on_n = 1, drive_sel_n = 4'hF, index_pulse = done = error = busy = 0, synchronisers = 1.
REQ-042 Reset mid-step SHALL return step_n high immediately; the host must RECAL afterwards.

Structure
REQ-043 Package fdc_pkg SHALL hold the cmd_op encodings (OP_SEEK, OP_RECAL), the state enum, and the default timing constants.
REQ-044 One sub-module, fdc_sync2 (two-flop synchroniser), SHALL be instantiated once per bus input.

Verification (STEP_PULSE_CYC=4, STEP_RATE_CYC=20, DIR_SETUP_CYC=2, SETTLE_CYC=10)
REQ-045 SEEK 5 from track 0 -> 5 step_n pulses, each low 4 cycles, period 20; dir_sel_n = 0; done once; cur_track = 5.
REQ-046 SEEK 2 from track 5 -> 3 pulses with dir_sel_n = 1; cur_track = 2; error = 0.
REQ-047 RECAL with the model asserting track_0_n after 7 steps -> exactly 7 pulses; cur_track = 0; error = 0.
REQ-048 RECAL with track_0_n stuck high -> 80 pulses; error = 1; done pulses once.
REQ-049 SEEK 80 -> no pulses; error = 1; done pulses. SEEK to cur_track -> done pulses with zero pulses.
REQ-050 rst low during the 3rd STEP_LO -> step_n = 1 and all outputs at reset values in the same cycle; index_n toggle -> one index_pulse per fall, 3 cycles later.
